// File: rtl/fifo_seq_ctrl.sv
// fifo_seq_ctrl: fills a bank of DIM delay FIFOs row by row, then drains them with a diagonal skew.
// Optional abort input when FIFO_SEQ_ABORT_EN is defined.
module fifo_seq_ctrl #(
  parameter int DIM  = 8,
  parameter int BITS = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
`ifdef FIFO_SEQ_ABORT_EN
  input  logic                abort,
`endif
  input  logic                in_valid,
  input  logic [DIM*BITS-1:0] in_row,
  output logic                in_ready,
  output logic [DIM-1:0]      fifo_en,
  output logic [DIM*BITS-1:0] fifo_d,
  output logic [DIM-1:0]      col_valid,
  output logic                busy,
  output logic                done
);
  localparam int CW = $clog2(2*DIM);
  typedef enum logic [1:0] {IDLE, FILL, DRAIN, DONE} state_t;
  state_t state, state_n;
  logic [CW-1:0] fill, fill_n, c, c_n;
  logic [DIM-1:0] skew;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      fill  <= '0;
      c     <= '0;
    end else begin
      state <= state_n;
      fill  <= fill_n;
      c     <= c_n;
    end
  end
  // FIFO i is read during drain steps i .. i+DIM-1, giving a diagonal wavefront
  always_comb begin
    skew = '0;
    for (int i = 0; i < DIM; i++)
      skew[i] = (int'(c) >= i) && (int'(c) < i + DIM);
  end
  always_comb begin
    state_n   = state;
    fill_n    = fill;
    c_n       = c;
    in_ready  = 1'b0;
    fifo_en   = '0;
    fifo_d    = '0;
    col_valid = '0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        fill_n = '0;
        if (start) state_n = FILL;
      end
      FILL: begin
        busy     = 1'b1;
        in_ready = 1'b1;
        if (in_valid) begin
          fifo_en = '1;
          fifo_d  = in_row;
          fill_n  = fill + CW'(1);
          if (fill == CW'(DIM - 1)) begin
            state_n = DRAIN;
            fill_n  = '0;
            c_n     = '0;
          end
        end
      end
      DRAIN: begin
        busy      = 1'b1;
        fifo_en   = skew;
        col_valid = skew;
        c_n       = c + CW'(1);
        if (c == CW'(2*DIM - 2)) begin
          state_n = DONE;
          c_n     = '0;
        end
      end
      default: begin
        done    = 1'b1;
        state_n = IDLE;
      end
    endcase
`ifdef FIFO_SEQ_ABORT_EN
    if (abort && busy) begin
      state_n   = IDLE;
      fill_n    = '0;
      c_n       = '0;
      fifo_en   = '0;
      fifo_d    = '0;
      col_valid = '0;
    end
`endif
  end
endmodule

// File: doc/fifo_seq_ctrl.md
FIFO_SEQ_CTRL -- requirements
Module: fifo_seq_ctrl

Interface
REQ-001 Parameter DIM, default 8: number of delay FIFOs in the bank; equals FIFO depth. Legal range 2..64.
REQ-002 Parameter BITS, default 64: element width of each FIFO.
REQ-003 clk  input  1  clock; all state updates on posedge clk.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  pulse requesting one fill/drain sequence.
REQ-006 in_valid  input  1  row word present on in_row.
REQ-007 in_row  input  DIM*BITS  one row; slice [i*BITS +: BITS] goes to FIFO i.
REQ-008 in_ready  output  1  controller accepts a row this cycle.
REQ-009 fifo_en  output  DIM  per-FIFO shift enable.
REQ-010 fifo_d  output  DIM*BITS  per-FIFO shift-in data.
REQ-011 col_valid  output  DIM  FIFO i head (q) is a valid output element this cycle.
REQ-012 busy  output  1  high in FILL or DRAIN.
REQ-013 done  output  1  one-cycle completion pulse.

Function
REQ-014 The controller SHALL implement states IDLE, FILL, DRAIN, DONE.
REQ-015 IDLE: start=1 SHALL move to FILL next cycle; all other inputs ignored.
REQ-016 FILL: in_ready SHALL be 1; an accept is in_valid & in_ready.
REQ-017 On accept, fifo_en SHALL be all-ones and fifo_d SHALL equal in_row in the same cycle; otherwise fifo_en SHALL be 0.
REQ-018 A fill counter SHALL count accepts; the DIM-th accept SHALL move to DRAIN next cycle and clear the drain counter c to 0. in_valid gaps SHALL stall without loss.
REQ-019 DRAIN: for c = 0..2*DIM-2, fifo_en[i] SHALL be 1 iff i <= c < i+DIM (skewed drain); fifo_d SHALL be all-zeros; col_valid SHALL equal fifo_en.
REQ-020 c SHALL increment every DRAIN cycle; after c = 2*DIM-2 the state SHALL move to DONE. Counter width SHALL be clog2(2*DIM).
REQ-021 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-022 busy SHALL be 1 in FILL and DRAIN only; in_ready, col_valid SHALL be 0 outside FILL/DRAIN respectively.
REQ-023 start while not in IDLE SHALL be ignored; start in DONE SHALL NOT be queued.
REQ-024 fifo_en, fifo_d, col_valid, in_ready SHALL be combinational decodes of state, counters and in_valid; state and counters SHALL be registered.

Reset
REQ-025 rst_n low SHALL asynchronously force IDLE, both counters 0; outputs then: in_ready=0, fifo_en=0, fifo_d=0, col_valid=0, busy=0, done=0.
REQ-026 Reset mid-FILL or mid-DRAIN SHALL abandon the sequence with no done pulse; FIFO contents are not cleared by this block.

Configuration
REQ-027 Macro FIFO_SEQ_ABORT_EN defined: input abort (1 bit) SHALL exist; abort=1 in FILL or DRAIN SHALL move to IDLE next cycle, clear counters, suppress fifo_en that cycle, no done pulse; abort has priority over accept and drain advance; abort in IDLE/DONE ignored.
REQ-028 Macro undefined: abort port SHALL be absent and behaviour SHALL be REQ-014..026 only.

Verification (DIM=4, BITS=8)
REQ-029 start, then 4 back-to-back rows 0x04030201,0x08070605,0x0C0B0A09,0x100F0E0D -> fifo_en=1111 for 4 cycles; DRAIN fifo_en sequence 0001,0011,0111,1111,1110,1100,1000; done one cycle later; busy high 11 cycles.
REQ-030 Same rows with in_valid low 2 cycles between each -> in_ready held 1, exactly 4 accepts, identical DRAIN pattern, no extra fifo_en pulses.
REQ-031 start re-pulsed during FILL and during DRAIN -> no effect; exactly one done; start on the cycle after done -> new FILL begins.
REQ-032 rst_n low at DRAIN c=3 -> all outputs 0 immediately (asynchronously); no done; next start runs a full sequence.
REQ-033 FIFO_SEQ_ABORT_EN defined, abort at DRAIN c=2 -> fifo_en=0 that cycle, IDLE next cycle, done never asserted; undefined build compiles without abort port.
